// File: rtl/ntt_stage_sequencer.sv
// ntt_stage_sequencer: control sequencer for the NTT datapath (load, butterfly stages, write-back, drain)
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   i_start                   begin an operation (accepted only in IDLE)
//   i_load_first, i_inverse   sampled with i_start: run LOAD first / inverse GS ordering
//   i_abort                   synchronous flush to IDLE, drops pending write-backs
//   i_in_valid                input coefficient valid during LOAD
//   o_in_sel                  high in LOAD, steers memory write data to the input stream
//   o_r_enable, o_ntt_enable  butterfly read strobe / operand valid
//   o_r_addr_a/b, o_tw_idx    butterfly read pair and twiddle index
//   o_w_en_a/b, o_w_addr_a/b  write strobes and addresses (load stream or delayed write-back)
//   o_mode_inv, o_stage       sampled mode and current stage
//   o_busy, o_done            not-IDLE flag and one-cycle completion pulse
module ntt_stage_sequencer #(
    parameter int LOG_N  = 8,
    parameter int BF_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_load_first,
    input  logic             i_inverse,
    input  logic             i_abort,
    input  logic             i_in_valid,
    output logic             o_in_sel,
    output logic             o_r_enable,
    output logic [LOG_N-1:0] o_r_addr_a,
    output logic [LOG_N-1:0] o_r_addr_b,
    output logic [LOG_N-1:0] o_tw_idx,
    output logic             o_ntt_enable,
    output logic             o_w_en_a,
    output logic             o_w_en_b,
    output logic [LOG_N-1:0] o_w_addr_a,
    output logic [LOG_N-1:0] o_w_addr_b,
    output logic             o_mode_inv,
    output logic [LOG_N-1:0] o_stage,
    output logic             o_busy,
    output logic             o_done
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam int DW = $clog2(BF_LAT + 1);
    localparam logic [LOG_N-1:0] ONE        = LOG_N'(1);
    localparam logic [LOG_N-1:0] STAGE_LAST = LOG_N'(LOG_N - 1);
    localparam logic [LOG_N-1:0] J_LAST     = LOG_N'((1 << (LOG_N - 1)) - 1);
    localparam logic [DW-1:0]    D_LAST     = DW'(BF_LAT - 1);

    logic [2:0]       r_state;
    logic             r_mode_inv;
    logic [LOG_N-1:0] r_stage;
    logic [LOG_N-1:0] r_j;
    logic [LOG_N-1:0] r_load_cnt;
    logic [DW-1:0]    r_drain;
    logic             r_dv [BF_LAT];
    logic [LOG_N-1:0] r_da [BF_LAT];
    logic [LOG_N-1:0] r_db [BF_LAT];

    logic             w_issue;
    logic             w_load;
    logic [LOG_N-1:0] w_lh;
    logic [LOG_N-1:0] w_glh;
    logic [LOG_N-1:0] w_h;
    logic [LOG_N-1:0] w_k;
    logic [LOG_N-1:0] w_addr_a;
    logic [LOG_N-1:0] w_addr_b;
    logic [LOG_N-1:0] w_tw;

    // w_lh = log2(half-span), w_glh = log2(group count); g<<(lh+1) is formed by masking j and shifting once
    always_comb begin
        w_issue  = r_state == S_ISSUE;
        w_load   = r_state == S_LOAD;
        w_lh     = r_mode_inv ? r_stage : STAGE_LAST - r_stage;
        w_glh    = r_mode_inv ? STAGE_LAST - r_stage : r_stage;
        w_h      = ONE << w_lh;
        w_k      = r_j & (w_h - ONE);
        w_addr_a = ((r_j & ~(w_h - ONE)) << 1) | w_k;
        w_addr_b = w_addr_a | w_h;
        w_tw     = (ONE << w_glh) + (r_j >> w_lh);
    end

    assign o_busy       = r_state != S_IDLE;
    assign o_done       = r_state == S_DONE;
    assign o_in_sel     = w_load;
    assign o_r_enable   = w_issue;
    assign o_ntt_enable = w_issue;
    assign o_r_addr_a   = w_issue ? w_addr_a : '0;
    assign o_r_addr_b   = w_issue ? w_addr_b : '0;
    assign o_tw_idx     = w_issue ? w_tw : '0;
    assign o_w_en_a     = w_load ? i_in_valid : r_dv[BF_LAT-1];
    assign o_w_en_b     = !w_load && r_dv[BF_LAT-1];
    assign o_w_addr_a   = w_load ? r_load_cnt : r_da[BF_LAT-1];
    assign o_w_addr_b   = r_db[BF_LAT-1];
    assign o_mode_inv   = r_mode_inv;
    assign o_stage      = r_stage;

    // write-back delay line; abort kills every in-flight valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BF_LAT; i++) begin
                r_dv[i] <= 1'b0;
                r_da[i] <= '0;
                r_db[i] <= '0;
            end
        end else begin
            r_dv[0] <= w_issue && !i_abort;
            r_da[0] <= w_addr_a;
            r_db[0] <= w_addr_b;
            for (int i = 1; i < BF_LAT; i++) begin
                r_dv[i] <= r_dv[i-1] && !i_abort;
                r_da[i] <= r_da[i-1];
                r_db[i] <= r_db[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_mode_inv <= 1'b0;
            r_stage    <= '0;
            r_j        <= '0;
            r_load_cnt <= '0;
            r_drain    <= '0;
        end else if (i_abort) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state    <= i_load_first ? S_LOAD : S_ISSUE;
                        r_mode_inv <= i_inverse;
                        r_stage    <= '0;
                        r_j        <= '0;
                        r_load_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    if (i_in_valid) begin
                        r_load_cnt <= r_load_cnt + ONE;
                        if (r_load_cnt == '1) r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_j     <= r_j == J_LAST ? '0 : r_j + ONE;
                    r_drain <= '0;
                    if (r_j == J_LAST) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    r_drain <= r_drain + DW'(1);
                    if (r_drain == D_LAST) begin
                        r_state <= r_stage == STAGE_LAST ? S_DONE : S_ISSUE;
                        if (r_stage != STAGE_LAST) r_stage <= r_stage + ONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// tb_ntt_stage_sequencer: self-checking bench for ntt_stage_sequencer with LOG_N=3, BF_LAT=2
module tb_ntt_stage_sequencer;
    localparam int LOG_N  = 3;
    localparam int BF_LAT = 2;

    typedef struct {
        bit load;
        bit inv;
        bit stray;
        int done_cyc;
    } vec_t;

    typedef struct {
        int a;
        int b;
        int tw;
        int st;
        int cyc;
    } rd_t;

    typedef struct {
        int a;
        int b;
        int cyc;
    } wr_t;

    logic clk = 1'b0;
    logic rst, start, load_first, inverse, abort, in_valid;
    logic in_sel, r_enable, ntt_enable, w_en_a, w_en_b, mode_inv, busy, done;
    logic [LOG_N-1:0] r_addr_a, r_addr_b, tw_idx, w_addr_a, w_addr_b, stage;
    logic [25:0] all_out;

    int n_chk = 0;
    int n_pass = 0;
    int pc = 0;
    int s0 = 0;
    int mc;
    int load_len = 0;
    int done_c = -1;
    int acc = 0;
    bit mon_en = 1'b0;
    bit exp_inv = 1'b0;
    rd_t rq[$];
    wr_t wq[$];
    int lq[$];
    vec_t vt[4];

    // forward-order read pairs and twiddles; inverse runs the same stages in reverse order
    int fa [12] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
    int fb [12] = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
    int ftw[12] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 5, 6, 7};

    ntt_stage_sequencer #(.LOG_N(LOG_N), .BF_LAT(BF_LAT)) dut (
        .clk(clk), .rst(rst), .i_start(start), .i_load_first(load_first), .i_inverse(inverse),
        .i_abort(abort), .i_in_valid(in_valid), .o_in_sel(in_sel), .o_r_enable(r_enable),
        .o_r_addr_a(r_addr_a), .o_r_addr_b(r_addr_b), .o_tw_idx(tw_idx), .o_ntt_enable(ntt_enable),
        .o_w_en_a(w_en_a), .o_w_en_b(w_en_b), .o_w_addr_a(w_addr_a), .o_w_addr_b(w_addr_b),
        .o_mode_inv(mode_inv), .o_stage(stage), .o_busy(busy), .o_done(done)
    );

    assign all_out = {in_sel, r_enable, r_addr_a, r_addr_b, tw_idx, ntt_enable, w_en_a, w_en_b,
                      w_addr_a, w_addr_b, mode_inv, stage, busy, done};

    always #5 clk = ~clk;
    always @(posedge clk) pc <= pc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, pc - s0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_reads(input bit inv, input int nst, input int base);
        for (int st = 0; st < nst; st++)
            for (int j = 0; j < 4; j++) begin
                int idx;
                idx = (inv ? 2 - st : st) * 4 + j;
                rq.push_back('{fa[idx], fb[idx], ftw[idx], st, base + 1 + st * 6 + j});
            end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mc = pc - s0;
            chk("in_sel", int'(in_sel), int'(mc >= 1 && mc <= load_len));
            if (busy) chk("mode_inv", int'(mode_inv), int'(exp_inv));
            if (in_sel) begin
                chk("load_w_en_b", int'(w_en_b), 0);
                if (w_en_a) begin
                    chk("load_pending", int'(lq.size() > 0), 1);
                    if (lq.size() > 0) chk("load_addr", int'(w_addr_a), lq.pop_front());
                end
            end else if (w_en_a || w_en_b) begin
                chk("wr_pending", int'(wq.size() > 0), 1);
                if (wq.size() > 0) begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("wr_both", int'(w_en_a && w_en_b), 1);
                    chk("wr_addr_a", int'(w_addr_a), w.a);
                    chk("wr_addr_b", int'(w_addr_b), w.b);
                    chk("wr_cycle", mc, w.cyc);
                end
            end
            if (r_enable) begin
                chk("rd_pending", int'(rq.size() > 0), 1);
                if (rq.size() > 0) begin
                    rd_t r;
                    r = rq.pop_front();
                    chk("rd_addr_a", int'(r_addr_a), r.a);
                    chk("rd_addr_b", int'(r_addr_b), r.b);
                    chk("rd_tw", int'(tw_idx), r.tw);
                    chk("rd_stage", int'(stage), r.st);
                    chk("rd_cycle", mc, r.cyc);
                    chk("ntt_enable", int'(ntt_enable), 1);
                    wq.push_back('{r.a, r.b, mc + BF_LAT});
                end
            end
            if (done && done_c < 0) done_c = mc;
        end
    end

    task automatic run_vec(input vec_t v);
        rq.delete(); wq.delete(); lq.delete();
        exp_inv = v.inv;
        load_len = v.load ? 10 : 0;
        done_c = -1;
        acc = 0;
        push_reads(v.inv, 3, load_len);
        start = 1'b1; load_first = v.load; inverse = v.inv; s0 = pc; mon_en = 1'b1;
        for (int c = 1; c <= 60 && done_c < 0; c++) begin
            step();
            start = v.stray && (c == 5 || c == v.done_cyc);
            in_valid = v.load && c <= load_len && c != 4 && c != 5;
            if (in_valid) lq.push_back(acc++);
        end
        #2;
        chk("done_cycle", done_c, v.done_cyc);
        chk("busy_after_done", int'(busy), 0);
        chk("done_one_cycle", int'(done), 0);
        chk("rd_left", rq.size(), 0);
        chk("wr_left", wq.size(), 0);
        chk("load_left", lq.size(), 0);
        mon_en = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        vt[0] = '{1'b0, 1'b0, 1'b0, 19};
        vt[1] = '{1'b0, 1'b1, 1'b0, 19};
        vt[2] = '{1'b1, 1'b0, 1'b0, 29};
        vt[3] = '{1'b0, 1'b0, 1'b1, 19};
        rst = 1'b1; start = 1'b0; load_first = 1'b0; inverse = 1'b0; abort = 1'b0; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_outputs", int'(all_out), 0);
        rst = 1'b0;
        step();
        for (int i = 0; i < 4; i++) run_vec(vt[i]);

        rq.delete(); wq.delete(); lq.delete();
        exp_inv = 1'b0; load_len = 0; done_c = -1;
        push_reads(1'b0, 2, 0);
        start = 1'b1; load_first = 1'b0; inverse = 1'b0; s0 = pc; mon_en = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            step();
            start = 1'b0;
            abort = c == 11;
            if (c >= 12) begin
                #2;
                chk("abort_quiet", int'(w_en_a | w_en_b | r_enable | done), 0);
                chk("abort_idle", int'(busy), 0);
            end
        end
        chk("abort_rd_left", rq.size(), 0);
        chk("abort_wr_dropped", wq.size(), 1);
        chk("abort_no_done", done_c, -1);
        mon_en = 1'b0;
        run_vec(vt[0]);

        start = 1'b1; load_first = 1'b0; inverse = 1'b0; s0 = pc;
        step();
        start = 1'b0;
        step();
        step();
        #2;
        chk("pre_rst_issue", int'(r_enable), 1);
        chk("pre_rst_wr", int'(w_en_a), 1);
        rst = 1'b1;
        #1;
        chk("async_rst_outputs", int'(all_out), 0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_busy", int'(busy), 0);
        step();
        run_vec(vt[0]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ntt_stage_sequencer.md
Name: ntt_stage_sequencer

Overview:
- Parametrised control sequencer for the NTT datapath.
- Optionally streams a new polynomial into data memory. Then issues LOG_N butterfly stages (forward Cooley-Tukey or inverse Gentleman-Sande), generating read/write pair addresses and twiddle indices.
- Delays write-back by the butterfly pipeline latency and drains between stages to avoid read-after-write hazards.
- Sits between the top-level host handshake and the data memory, twiddle ROM and butterfly unit.

Parameters:
- LOG_N, 8, log2 of polynomial length N (legal range ≥ 2; N = 2^LOG_N).
- BF_LAT, 4, butterfly pipeline latency in cycles from read issue to write-back (legal range ≥ 1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin an operation; honoured only in IDLE
- load_first  in  1  sampled with start; 1 = run LOAD phase before stages
- inverse  in  1  sampled with start; 0 = forward CT, 1 = inverse GS
- abort  in  1  synchronous flush to IDLE
- in_valid  in  1  input coefficient valid during LOAD
- in_sel  out  1  high in LOAD; steers DM write data mux to the input stream
- r_enable  out  1  butterfly read strobe
- r_addr_a  out  LOG_N  butterfly upper address
- r_addr_b  out  LOG_N  butterfly lower address
- tw_idx  out  LOG_N  twiddle ROM index, valid with r_enable
- ntt_enable  out  1  butterfly unit operand valid (same cycle as r_enable)
- w_en_a  out  1  write strobe, port A
- w_en_b  out  1  write strobe, port B
- w_addr_a  out  LOG_N  write address, port A
- w_addr_b  out  LOG_N  write address, port B
- mode_inv  out  1  registered copy of sampled inverse
- stage  out  LOG_N  current stage number
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle completion pulse

Behaviour:
- States: IDLE, LOAD, ISSUE, DRAIN, DONE. Reset and abort both force IDLE.
- Reset value of every output is 0. Reset also clears counters, the sampled mode and the write-back delay line.
- IDLE:
  - start=1 samples load_first and inverse, then moves to LOAD if load_first=1, else to ISSUE.
  - start outside IDLE is ignored.
- LOAD:
  - in_sel=1 throughout.
  - Each cycle with in_valid=1: w_en_a=1, w_addr_a = load count; the count then increments. The write is combinational from in_valid.
  - When the N-th coefficient is accepted, go to ISSUE at stage 0.
  - Gaps in in_valid are allowed.
- ISSUE: one butterfly per cycle for j = 0..N/2-1, with r_enable = ntt_enable = 1.
  - Half-span h: forward h = N >> (s+1); inverse h = 1 << s.
  - Derived terms: g = j / h, k = j mod h, groups = N/(2h).
  - r_addr_a = 2hg + k; r_addr_b = r_addr_a + h; tw_idx = groups + g.
  - After j = N/2-1, go to DRAIN.
- DRAIN:
  - Lasts exactly BF_LAT cycles with r_enable = 0.
  - Then, if s < LOG_N-1: s increments and the state returns to ISSUE.
  - Otherwise go to DONE.
- Write-back:
  - A BF_LAT-deep shift register carries {valid, addr_a, addr_b}.
  - A read issued at cycle t produces w_en_a = w_en_b = 1 with the same addresses at t+BF_LAT.
  - The last write of a stage coincides with the last DRAIN cycle. The next stage's first read is the following cycle.
- DONE: done = 1 for one cycle, then IDLE. busy = 0 in IDLE. start in DONE is ignored.
- Timing:
  - With load_first = 0 and start at cycle 0, the first read is at cycle 1.
  - done is at cycle LOG_N·(N/2+BF_LAT)+1.
  - With load_first = 1, add the LOAD duration.
- abort:
  - Any state goes to IDLE next cycle; delay-line valids are cleared, so no further writes occur.
  - done is not asserted.
  - abort has priority over start in the same cycle.
- Reset mid-operation: all outputs go to 0 immediately (asynchronously); no partial write completes.
- Width rules:
  - Address arithmetic is LOG_N bits with no overflow by construction.
  - tw_idx ranges 1..N-1; index 0 is never issued.

Test Plan:
1. LOG_N=3, BF_LAT=2, forward, load_first=0, start at cycle 0 → reads occur in this order:
   - Stage 0: (0,4)(1,5)(2,6)(3,7), tw 1,1,1,1.
   - Stage 1: (0,2)(1,3)(4,6)(5,7), tw 2,2,3,3.
   - Stage 2: (0,1)(2,3)(4,5)(6,7), tw 4,5,6,7.
   - Writes mirror each read 2 cycles later; done pulses at cycle 19; busy falls the cycle after done.
2. Same parameters, inverse=1 → reads occur in this order:
   - Stage 0: (0,1)(2,3)(4,5)(6,7), tw 4,5,6,7.
   - Stage 1: (0,2)(1,3)(4,6)(5,7), tw 2,2,3,3.
   - Stage 2: (0,4)..(3,7), tw 1.
   - mode_inv = 1 throughout.
3. load_first=1, in_valid asserted for 8 coefficients with a 2-cycle gap after the 3rd → in_sel high only in LOAD; w_en_a on addresses 0..7 in order; w_en_b = 0; first r_enable the cycle after the 8th accept.
4. abort during stage 1 DRAIN → no w_en in the following cycles; IDLE next cycle; done never pulses; a subsequent start restarts at stage 0.
5. start asserted in ISSUE and in DONE → ignored: sequence and timing identical to scenario 1.
6. rst asserted mid-ISSUE (asynchronously) → all outputs 0 before the next clock edge. After release, IDLE with busy = 0, and a start reproduces scenario 1 exactly.
